// File: rtl/snn_ctrl_pkg.sv
// Shared control-path types and default widths for the spike pattern memory,
// the pattern sequencer and the neuron array.
package snn_ctrl_pkg;

  localparam int unsigned TIMESTEP_ADDR_WIDTH_DEF            = 8;
  localparam int unsigned SPIKE_PATTERN_BATCH_ADDR_WIDTH_DEF = 6;
  localparam int unsigned SPIKES_PER_BATCH_DEF               = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/spike_pattern_sequencer_if.sv
// Host, playback and memory-side signals of the spike pattern sequencer.
interface spike_pattern_sequencer_if #(
  parameter int unsigned TIMESTEP_ADDR_WIDTH            = 8,
  parameter int unsigned SPIKE_PATTERN_BATCH_ADDR_WIDTH = 6,
  parameter int unsigned SPIKES_PER_BATCH               = 32
);
  logic                                      host_wen;
  logic                                      host_ren;
  logic [TIMESTEP_ADDR_WIDTH-1:0]            host_addr;
  logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] host_batch;
  logic [SPIKES_PER_BATCH-1:0]               host_wdata;
  logic [SPIKES_PER_BATCH-1:0]               host_rdata;
  logic                                      host_rvalid;
  logic                                      host_err;
  logic                                      start;
  logic                                      abort;
  logic [TIMESTEP_ADDR_WIDTH-1:0]            last_timestep;
  logic                                      net_ready;
  logic                                      busy;
  logic                                      timestep_valid;
  logic [TIMESTEP_ADDR_WIDTH-1:0]            timestep_idx;
  logic                                      done;
  logic [TIMESTEP_ADDR_WIDTH-1:0]            mem_addr;
  logic                                      mem_wen;
  logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] batch_sel;
  logic [SPIKES_PER_BATCH-1:0]               mem_data_in;
  logic [SPIKES_PER_BATCH-1:0]               mem_data_out;

  modport master (
    input  host_wen, host_ren, host_addr, host_batch, host_wdata,
    input  start, abort, last_timestep, net_ready, mem_data_out,
    output host_rdata, host_rvalid, host_err,
    output busy, timestep_valid, timestep_idx, done,
    output mem_addr, mem_wen, batch_sel, mem_data_in
  );

  modport slave (
    output host_wen, host_ren, host_addr, host_batch, host_wdata,
    output start, abort, last_timestep, net_ready, mem_data_out,
    input  host_rdata, host_rvalid, host_err,
    input  busy, timestep_valid, timestep_idx, done,
    input  mem_addr, mem_wen, batch_sel, mem_data_in
  );

endinterface

// File: rtl/spike_pattern_sequencer_host_port.sv
// Memory input mux (host in IDLE, playback otherwise), host error flagging and
// the two-cycle readback pipe.
module spike_mem_host_port #(
  parameter int unsigned AW = 8,
  parameter int unsigned BW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_idle,
  input  logic          i_start,
  input  logic          i_host_wen,
  input  logic          i_host_ren,
  input  logic [AW-1:0] i_host_addr,
  input  logic [BW-1:0] i_host_batch,
  input  logic [DW-1:0] i_host_wdata,
  input  logic [AW-1:0] i_play_addr,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_wen,
  output logic [BW-1:0] o_batch_sel,
  output logic [DW-1:0] o_mem_wdata,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_host_rvalid,
  output logic          o_host_err
);

  logic          w_accept;
  logic          w_rd_ok;
  logic          w_err;
  logic          r_rd_pend;
  logic          r_rvalid;
  logic          r_err;
  logic [DW-1:0] r_rdata;

  // A start in the same cycle steals the memory, so the host is locked out.
  assign w_accept = i_idle & ~i_start;
  assign w_rd_ok  = w_accept & i_host_ren & ~i_host_wen;
  assign w_err    = ((i_host_wen | i_host_ren) & ~w_accept) | (i_host_wen & i_host_ren);

  // Gated by rst_n so every memory-side output reads 0 while in reset.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wen   = 1'b0;
    o_batch_sel = '0;
    o_mem_wdata = '0;
    if (rst_n) begin
      if (i_idle) begin
        o_mem_addr  = i_host_addr;
        o_batch_sel = i_host_batch;
        o_mem_wdata = i_host_wdata;
        o_mem_wen   = w_accept & i_host_wen;
      end else begin
        o_mem_addr  = i_play_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_pend <= w_rd_ok;
      r_rvalid  <= r_rd_pend;
      r_err     <= w_err;
      if (r_rd_pend) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_host_rdata  = r_rdata;
  assign o_host_rvalid = r_rvalid;
  assign o_host_err    = r_err;

endmodule

// File: rtl/spike_pattern_sequencer.sv
// Playback sequencer for the spike pattern memory: steps timesteps 0..last,
// handshaking each with the neuron array, and lends the memory to the host in IDLE.
module spike_pattern_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned TIMESTEP_ADDR_WIDTH            = TIMESTEP_ADDR_WIDTH_DEF,
  parameter int unsigned SPIKE_PATTERN_BATCH_ADDR_WIDTH = SPIKE_PATTERN_BATCH_ADDR_WIDTH_DEF,
  parameter int unsigned SPIKES_PER_BATCH               = SPIKES_PER_BATCH_DEF
) (
  input logic                       clk,
  input logic                       rst_n,
  spike_pattern_sequencer_if.master bus
);

  localparam int unsigned AW = TIMESTEP_ADDR_WIDTH;

  seq_state_t      r_state;
  seq_state_t      w_state_d;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_d;
  logic [AW-1:0]   r_last;
  logic [AW-1:0]   w_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_last_d  = r_last;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_d = FETCH;
          w_idx_d   = '0;
          w_last_d  = bus.last_timestep;
        end
      end
      FETCH:   w_state_d = bus.abort ? IDLE : PRESENT;
      PRESENT: w_state_d = bus.abort ? IDLE : WAIT;
      WAIT: begin
        // Abort wins over net_ready; DONE at equality means the index never wraps.
        if (bus.abort) begin
          w_state_d = IDLE;
        end else if (bus.net_ready) begin
          if (r_idx == r_last) begin
            w_state_d = DONE;
          end else begin
            w_state_d = FETCH;
            w_idx_d   = r_idx + 1'b1;
          end
        end
      end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  assign bus.busy           = (r_state != IDLE);
  assign bus.timestep_valid = (r_state == PRESENT);
  assign bus.done           = (r_state == DONE);
  assign bus.timestep_idx   = r_idx;

  spike_mem_host_port #(
    .AW (TIMESTEP_ADDR_WIDTH),
    .BW (SPIKE_PATTERN_BATCH_ADDR_WIDTH),
    .DW (SPIKES_PER_BATCH)
  ) u_host_port (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_idle        (r_state == IDLE),
    .i_start       (bus.start),
    .i_host_wen    (bus.host_wen),
    .i_host_ren    (bus.host_ren),
    .i_host_addr   (bus.host_addr),
    .i_host_batch  (bus.host_batch),
    .i_host_wdata  (bus.host_wdata),
    .i_play_addr   (r_idx),
    .i_mem_rdata   (bus.mem_data_out),
    .o_mem_addr    (bus.mem_addr),
    .o_mem_wen     (bus.mem_wen),
    .o_batch_sel   (bus.batch_sel),
    .o_mem_wdata   (bus.mem_data_in),
    .o_host_rdata  (bus.host_rdata),
    .o_host_rvalid (bus.host_rvalid),
    .o_host_err    (bus.host_err)
  );

endmodule

// File: tb/tb_spike_pattern_sequencer.sv
// Directed bench for spike_pattern_sequencer with a behavioural pattern memory.
module tb_spike_pattern_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  spike_pattern_sequencer_if #(
    .TIMESTEP_ADDR_WIDTH            (8),
    .SPIKE_PATTERN_BATCH_ADDR_WIDTH (6),
    .SPIKES_PER_BATCH               (32)
  ) bus ();

  spike_pattern_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory: write at the edge, read data one cycle after address.
  logic [31:0] tb_mem [0:255][0:63];
  always @(posedge clk) begin
    if (bus.mem_wen) tb_mem[bus.mem_addr][bus.batch_sel] <= bus.mem_data_in;
    bus.mem_data_out <= tb_mem[bus.mem_addr][bus.batch_sel];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [5:0] b, input logic [31:0] d);
    bus.host_wen   = 1'b1;
    bus.host_addr  = a;
    bus.host_batch = b;
    bus.host_wdata = d;
    tick();
    bus.host_wen   = 1'b0;
  endtask

  // Returns two edges after issuing the read, when rvalid should be high.
  task automatic host_read(input logic [7:0] a, input logic [5:0] b);
    bus.host_ren   = 1'b1;
    bus.host_addr  = a;
    bus.host_batch = b;
    tick();
    bus.host_ren   = 1'b0;
    chk("rvalid_early", bus.host_rvalid, 0);
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.host_wen      = 1'b0;
    bus.host_ren      = 1'b0;
    bus.host_addr     = '0;
    bus.host_batch    = '0;
    bus.host_wdata    = '0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.last_timestep = '0;
    bus.net_ready     = 1'b0;

    repeat (2) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_idx", bus.timestep_idx, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    chk("rst_rvalid", bus.host_rvalid, 0);
    rst_n = 1'b1;
    tick();

    // Host write then readback
    bus.host_wen   = 1'b1;
    bus.host_addr  = 8'd5;
    bus.host_batch = 6'd1;
    bus.host_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_mem_wen", bus.mem_wen, 1);
    chk("wr_mem_addr", bus.mem_addr, 5);
    chk("wr_batch_sel", bus.batch_sel, 1);
    chk("wr_mem_data", bus.mem_data_in, 32'hDEADBEEF);
    tick();
    bus.host_wen = 1'b0;
    host_read(8'd5, 6'd1);
    chk("rd_rvalid", bus.host_rvalid, 1);
    chk("rd_rdata", bus.host_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_pulse", bus.host_rvalid, 0);
    chk("rd_rdata_held", bus.host_rdata, 32'hDEADBEEF);

    host_write(8'd7, 6'd0, 32'h12345678);
    host_write(8'd1, 6'd0, 32'hCAFE0001);

    // Write and read together: write lands, read dropped, error next cycle
    bus.host_wen   = 1'b1;
    bus.host_ren   = 1'b1;
    bus.host_addr  = 8'd9;
    bus.host_batch = 6'd2;
    bus.host_wdata = 32'hA5A5A5A5;
    tick();
    bus.host_wen = 1'b0;
    bus.host_ren = 1'b0;
    chk("wr_rd_err", bus.host_err, 1);
    tick();
    chk("wr_rd_err_pulse", bus.host_err, 0);
    chk("wr_rd_no_rvalid", bus.host_rvalid, 0);
    host_read(8'd9, 6'd2);
    chk("wr_rd_data", bus.host_rdata, 32'hA5A5A5A5);

    // Playback of 3 timesteps with net_ready tied high
    bus.last_timestep = 8'd2;
    bus.net_ready     = 1'b1;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pb_fetch_addr", bus.mem_addr, i);
      chk("pb_fetch_valid", bus.timestep_valid, 0);
      chk("pb_fetch_busy", bus.busy, 1);
      tick();
      chk("pb_present_valid", bus.timestep_valid, 1);
      chk("pb_present_idx", bus.timestep_idx, i);
      if (i == 1) chk("pb_spikes", bus.mem_data_out, 32'hCAFE0001);
      tick();
      chk("pb_wait_valid", bus.timestep_valid, 0);
      chk("pb_wait_done", bus.done, 0);
      tick();
    end
    chk("pb_done", bus.done, 1);
    chk("pb_done_idx", bus.timestep_idx, 2);
    chk("pb_done_busy", bus.busy, 1);
    tick();
    chk("pb_idle_busy", bus.busy, 0);
    chk("pb_idle_done", bus.done, 0);

    // Stall at idx 1, reject host write, then abort at idx 3
    bus.last_timestep = 8'd3;
    bus.net_ready     = 1'b0;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.net_ready = 1'b1;
    tick();
    bus.net_ready = 1'b0;
    chk("st_fetch_addr", bus.mem_addr, 1);
    tick();
    chk("st_present_valid", bus.timestep_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("st_hold_addr", bus.mem_addr, 1);
      chk("st_hold_valid", bus.timestep_valid, 0);
      chk("st_hold_idx", bus.timestep_idx, 1);
    end
    bus.host_wen   = 1'b1;
    bus.host_addr  = 8'd7;
    bus.host_batch = 6'd0;
    bus.host_wdata = 32'hBAD0BAD0;
    #1;
    chk("busy_wr_wen", bus.mem_wen, 0);
    chk("busy_wr_addr", bus.mem_addr, 1);
    tick();
    bus.host_wen = 1'b0;
    chk("busy_wr_err", bus.host_err, 1);
    bus.net_ready = 1'b1;
    tick();
    chk("st_advance_idx", bus.timestep_idx, 2);
    chk("st_advance_addr", bus.mem_addr, 2);
    chk("busy_wr_err_pulse", bus.host_err, 0);
    tick();
    tick();
    tick();
    bus.net_ready = 1'b0;
    chk("ab_fetch_idx", bus.timestep_idx, 3);
    tick();
    tick();
    bus.abort     = 1'b1;
    bus.net_ready = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.net_ready = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_no_done", bus.done, 0);
    chk("ab_idx", bus.timestep_idx, 3);
    tick();
    chk("ab_no_done_later", bus.done, 0);
    host_read(8'd7, 6'd0);
    chk("busy_wr_unchanged", bus.host_rdata, 32'h12345678);

    // last_timestep=0 plays one step; start/last changes while busy ignored
    bus.last_timestep = 8'd0;
    bus.net_ready     = 1'b1;
    bus.start         = 1'b1;
    tick();
    chk("one_restart_idx", bus.timestep_idx, 0);
    chk("one_restart_addr", bus.mem_addr, 0);
    bus.last_timestep = 8'd5;
    tick();
    bus.start = 1'b0;
    chk("one_valid", bus.timestep_valid, 1);
    tick();
    tick();
    chk("one_done", bus.done, 1);
    chk("one_done_idx", bus.timestep_idx, 0);
    tick();
    chk("one_idle", bus.busy, 0);

    // Asynchronous reset mid-playback
    bus.last_timestep = 8'd4;
    bus.net_ready     = 1'b0;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_valid", bus.timestep_valid, 0);
    chk("arst_idx", bus.timestep_idx, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_rdata", bus.host_rdata, 0);
    chk("arst_done", bus.done, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("arst_rel_busy", bus.busy, 0);
    chk("arst_rel_done", bus.done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_pattern_sequencer.md
Name: spike_pattern_sequencer

Overview:
- Controller for the spike pattern memory. It owns the memory's address, write-enable, batch-select and write-data inputs.
- It shares the memory between a host load/readback port and a playback engine.
- The playback engine steps the memory through timesteps 0..last_timestep and presents each timestep's spike vector to the downstream neuron array.
- It waits for a downstream ready handshake before advancing to the next timestep.

Parameters:
TIMESTEP_ADDR_WIDTH, 8, width of timestep address (memory depth 2**TIMESTEP_ADDR_WIDTH)
SPIKE_PATTERN_BATCH_ADDR_WIDTH, 6, width of batch select
SPIKES_PER_BATCH, 32, width of one host data word / batch

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
host_wen  in  1  host write request (single-cycle)
host_ren  in  1  host read request (single-cycle)
host_addr  in  TIMESTEP_ADDR_WIDTH  host timestep address
host_batch  in  SPIKE_PATTERN_BATCH_ADDR_WIDTH  host batch select
host_wdata  in  SPIKES_PER_BATCH  host write data
host_rdata  out  SPIKES_PER_BATCH  readback data, valid when host_rvalid
host_rvalid  out  1  one-cycle readback-valid pulse
host_err  out  1  one-cycle pulse: host request rejected
start  in  1  begin playback (sampled in IDLE only)
abort  in  1  terminate playback
last_timestep  in  TIMESTEP_ADDR_WIDTH  final timestep index, inclusive; captured at start
net_ready  in  1  downstream has consumed current timestep
busy  out  1  playback in progress (any non-IDLE state)
timestep_valid  out  1  one-cycle pulse: memory spike output holds timestep_idx
timestep_idx  out  TIMESTEP_ADDR_WIDTH  current playback timestep
done  out  1  one-cycle pulse after last timestep is acknowledged
mem_addr  out  TIMESTEP_ADDR_WIDTH  to memory
mem_wen  out  1  to memory
batch_sel  out  SPIKE_PATTERN_BATCH_ADDR_WIDTH  to memory
mem_data_in  out  SPIKES_PER_BATCH  to memory
mem_data_out  in  SPIKES_PER_BATCH  from memory (registered, 1-cycle read latency)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0, including timestep_idx, mem_addr and host_rdata. Captured last_timestep is cleared to 0. Reset mid-playback aborts immediately, with no done pulse.
- Memory timing: a write commits at the clock edge where mem_wen=1. The spike vector and mem_data_out reflect mem_addr one cycle after the edge at which mem_addr is presented.
- IDLE, host access:
  - mem_addr/batch_sel/mem_data_in mirror host_addr/host_batch/host_wdata combinationally; mem_wen=host_wen.
  - host_ren: host_rvalid pulses 2 cycles later with host_rdata = mem_data_out; host_rdata is registered and held until the next read.
  - host_wen and host_ren together: the write proceeds, the read is dropped, and host_err pulses the next cycle.
- IDLE, start:
  - start=1 captures last_timestep, clears timestep_idx to 0 and moves to FETCH.
  - A host request in the same cycle is rejected: mem_wen=0, host_err pulses.
- Host request in any non-IDLE state: mem_wen forced 0, no rvalid, host_err pulses the next cycle.
- Playback states:
  - FETCH: mem_addr=timestep_idx, batch_sel=0, mem_wen=0. Next state PRESENT.
  - PRESENT: mem_addr held; timestep_valid=1 for this one cycle. Next state WAIT.
  - WAIT: mem_addr held, so the spike vector stays stable. net_ready is sampled only here.
    - net_ready=1 and timestep_idx==captured last → DONE.
    - net_ready=1 otherwise → timestep_idx+1, then FETCH.
  - DONE: done=1 for one cycle, timestep_idx held, next state IDLE.
  - Minimum period is 3 cycles per timestep.
- busy=1 in FETCH, PRESENT, WAIT and DONE.
- start while busy is ignored.
- abort=1 in FETCH/PRESENT/WAIT → IDLE next edge; no done pulse, timestep_idx retained. abort has priority over net_ready in the same cycle. abort in IDLE or DONE has no effect.
- last_timestep = 2**TIMESTEP_ADDR_WIDTH-1 is legal. The index never wraps, because DONE is taken at equality.
- last_timestep=0 plays exactly one timestep.

Decomposition:
- Shared package snn_ctrl_pkg:
  - seq_state_t enum {IDLE, FETCH, PRESENT, WAIT, DONE}
  - default width localparams shared with the memory and neuron blocks
- Optional sub-module spike_mem_host_port: the IDLE mux, the host_err logic and the rvalid delay pipe.
- The FSM and timestep counter stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously; busy=0 after release.
- Host write addr 5, batch 1, data 0xDEADBEEF, then host read same location → host_rvalid pulses 2 cycles after the read with host_rdata=0xDEADBEEF.
- last_timestep=2, net_ready tied 1, start → timestep_valid pulses for idx 0,1,2, 3 cycles apart; done pulses 2 cycles after the idx 2 valid pulse; busy falls with IDLE.
- Hold net_ready=0 for 10 cycles at idx 1 → mem_addr stays 1, single timestep_valid pulse, no advance; advances 1 cycle after net_ready=1.
- Host write during playback → host_err pulse, mem_wen stays 0, memory contents unchanged on later readback.
- abort in WAIT at idx 3 together with net_ready=1 → IDLE next cycle, no done, timestep_idx=3; a following start restarts at idx 0.
